draw_scheduler: RTL and testbench
=================================

// Module: draw_scheduler
// PURPOSE
//  Shares the single VGA adapter write port between up to 4 drawing units
//  (background, game-over screen, sprites, score), each using a plot/done handshake.
//  Picks one requesting unit round-robin and pulses its plot input.
//  Muxes that unit's x/y/colour/writeEn to the adapter until it signals done.
//  A watchdog aborts a unit that never returns done.
// PARAMETERS
//  TIMEOUT  200000  max BUSY cycles per grant before abort (>=2; counter 18 bits)
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   synchronous, active-low reset
//  req          in   4   level request per unit; bit i = unit i
//  unit_done    in   4   1-cycle done pulse from each unit
//  unit_x       in   36  packed x per unit, [9i+8:9i]
//  unit_y       in   32  packed y per unit, [8i+7:8i]
//  unit_colour  in   12  packed colour per unit, [3i+2:3i]
//  unit_we      in   4   writeEn per unit
//  plot         out  4   1-cycle start pulse to the granted unit (one-hot or 0)
//  grant        out  4   one-hot owner of the write port (0 when none)
//  vga_x        out  9   muxed x to the VGA adapter
//  vga_y        out  8   muxed y
//  vga_colour   out  3   muxed colour
//  vga_we       out  1   muxed writeEn
//  busy         out  1   1 in any state other than IDLE
//  timeout_err  out  1   1-cycle pulse when a grant is aborted by the watchdog
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=IDLE, grant=0, plot=0, last=3,
//   wd_cnt=0, timeout_err=0. Reset mid-draw drops the grant on the next edge.
//  Registered outputs: plot, grant, timeout_err, busy (decoded from state).
//  vga_* are combinational from grant:
//   - grant==0: vga_we=0, vga_x=0, vga_y=0, vga_colour=0.
//   - else the granted unit's fields, passed straight through (0 added latency).
//  FSM:
//   IDLE:  if req!=0, choose g = first set bit searching last+1, last+2, ... mod 4.
//          Load grant=onehot(g), plot=onehot(g); go to PLOT.
//          If req==0, stay.
//   PLOT:  plot high for exactly this cycle; wd_cnt=0; go to BUSY.
//          A done during PLOT is ignored.
//   BUSY:  plot=0; wd_cnt+1 per cycle.
//          - unit_done[g]=1: go to GAP (normal completion).
//          - wd_cnt==TIMEOUT-1 and no done: go to GAP, timeout_err=1 for 1 cycle.
//          - done and timeout in the same cycle: counted as done, no error.
//          - unit_done on a non-granted bit is ignored.
//   GAP:   grant=0, last=g; go to IDLE.
//          Guarantees >=1 idle-port cycle between owners.
//  Latency: req seen in IDLE at edge k -> plot high in cycle k+1.
//   After done at edge d -> next plot earliest at d+3.
//  Fairness: with all 4 requesting continuously, grant order is 0,1,2,3,0,...
//  req dropped after grant does not abort the draw; only done/timeout end it.
//  A unit whose req stays high is re-granted only after the others get a turn.
// TESTING
//  1. Reset, req=0001 -> plot=0001 one cycle, grant=0001 until done, then GAP, IDLE.
//  2. req=1111 held; each unit sends done 5 cycles after its plot -> grants 0,1,2,3,0.
//  3. Granted unit 2, unit_x[26:18]=9'd40, unit_we[2]=1, unit_we[0]=1
//     -> vga_x=40, vga_we=1; unit 0 writes never reach the adapter.
//  4. TIMEOUT=16, unit never sends done -> abort after 16 BUSY cycles,
//     timeout_err pulses once, next requester is granted.
//  5. unit_done[1]=1 while grant=0001 -> ignored, stays BUSY;
//     done on the 16th BUSY cycle (same cycle as timeout) -> no timeout_err.
//  6. resetn=0 during BUSY -> next edge grant=0, plot=0, vga_we=0, busy=0;
//     after release, the round-robin pointer restarts at unit 0.

Source files
------------

// File: rtl/draw_scheduler.sv
// Round-robin arbiter sharing one VGA adapter write port between four drawing units.
// Grants one unit at a time via a plot/done handshake, with a watchdog abort on missing done.
module draw_scheduler #(
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [3:0]  unit_done,
  input  logic [35:0] unit_x,
  input  logic [31:0] unit_y,
  input  logic [11:0] unit_colour,
  input  logic [3:0]  unit_we,
  output logic [3:0]  plot,
  output logic [3:0]  grant,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_we,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_BUSY, S_GAP} state_t;

  localparam logic [17:0] WD_LAST = 18'(TIMEOUT - 1);

  state_t      state_q;
  logic [3:0]  grant_q;
  logic [3:0]  plot_q;
  logic [1:0]  last_q;
  logic [1:0]  gidx_q;
  logic [17:0] wd_cnt_q;
  logic        terr_q;

  logic        pick_found_d;
  logic [1:0]  pick_idx_d;
  logic [1:0]  cand;

  // Search starts just after the last owner, so a unit holding req high waits its turn.
  always_comb begin
    pick_found_d = 1'b0;
    pick_idx_d   = '0;
    cand         = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_found_d && req[cand]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      plot_q   <= '0;
      last_q   <= 2'd3;
      gidx_q   <= '0;
      wd_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      plot_q <= '0;
      terr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found_d) begin
            gidx_q  <= pick_idx_d;
            grant_q <= 4'b0001 << pick_idx_d;
            plot_q  <= 4'b0001 << pick_idx_d;
            state_q <= S_PLOT;
          end
        end
        S_PLOT: begin
          wd_cnt_q <= '0;
          state_q  <= S_BUSY;
        end
        S_BUSY: begin
          // Done wins over a simultaneous watchdog expiry.
          if (unit_done[gidx_q]) begin
            grant_q <= '0;
            state_q <= S_GAP;
          end else if (wd_cnt_q == WD_LAST) begin
            grant_q <= '0;
            terr_q  <= 1'b1;
            state_q <= S_GAP;
          end else begin
            wd_cnt_q <= wd_cnt_q + 18'd1;
          end
        end
        S_GAP: begin
          last_q  <= gidx_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // grant_q is one-hot or zero, so an OR of masked fields is a clean mux.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_we     = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        vga_x      = vga_x      | unit_x[9*i +: 9];
        vga_y      = vga_y      | unit_y[8*i +: 8];
        vga_colour = vga_colour | unit_colour[3*i +: 3];
        vga_we     = vga_we     | unit_we[i];
      end
    end
  end

  assign plot        = plot_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: cycle tables for handshake and mux, plus
// hand sequences for fairness, watchdog, done/timeout race and mid-draw reset.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [3:0]  unit_done;
  logic [35:0] unit_x;
  logic [31:0] unit_y;
  logic [11:0] unit_colour;
  logic [3:0]  unit_we;
  logic [3:0]  plot;
  logic [3:0]  grant;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_we;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  draw_scheduler #(.TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .req(req), .unit_done(unit_done),
    .unit_x(unit_x), .unit_y(unit_y), .unit_colour(unit_colour), .unit_we(unit_we),
    .plot(plot), .grant(grant), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_we(vga_we), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] plot;
    logic [3:0] grant;
    logic       busy;
    logic       terr;
  } cyc_vec_t;

  typedef struct {
    logic [35:0] ux;
    logic [31:0] uy;
    logic [11:0] uc;
    logic [3:0]  uwe;
    logic [8:0]  ex;
    logic [7:0]  ey;
    logic [2:0]  ec;
    logic        ewe;
  } mux_vec_t;

  cyc_vec_t cyc_tab[6];
  mux_vec_t mux_tab[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req       = '0;
    unit_done = '0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [3:0] oh;

    cyc_tab[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b0};
    cyc_tab[1] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0};
    cyc_tab[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0};
    cyc_tab[3] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
    cyc_tab[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    cyc_tab[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    mux_tab[0] = '{{9'd7, 9'd40, 9'd300, 9'd1}, {8'd9, 8'd200, 8'd5, 8'd3},
                   {3'd1, 3'd6, 3'd2, 3'd7}, 4'b0101, 9'd40, 8'd200, 3'd6, 1'b1};
    mux_tab[1] = '{{9'd0, 9'd511, 9'd0, 9'd100}, {8'd0, 8'd0, 8'd0, 8'd77},
                   12'd0, 4'b0001, 9'd511, 8'd0, 3'd0, 1'b0};
    mux_tab[2] = '{{9'd1, 9'd0, 9'd2, 9'd3}, {8'd255, 8'd119, 8'd1, 8'd2},
                   {3'd7, 3'd3, 3'd7, 3'd7}, 4'b1011, 9'd0, 8'd119, 3'd3, 1'b0};
    mux_tab[3] = '{{4{9'h1ff}}, {4{8'hff}}, {4{3'h7}}, 4'b0100, 9'd511, 8'd255, 3'd7, 1'b1};

    unit_x = '1; unit_y = '1; unit_colour = '1; unit_we = '1;

    // Reset state, with all unit outputs driven high to prove the idle mux is zero.
    do_reset();
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_vga_we", 32'(vga_we), 32'd0);
    chk("rst_vga_x", 32'(vga_x), 32'd0);
    chk("rst_vga_y", 32'(vga_y), 32'd0);
    chk("rst_vga_c", 32'(vga_colour), 32'd0);

    // Single requester: plot one cycle, done in PLOT ignored, GAP, IDLE.
    for (int i = 0; i < 6; i++) begin
      req       = cyc_tab[i].req;
      unit_done = cyc_tab[i].done;
      step();
      chk($sformatf("t1_plot[%0d]", i), 32'(plot), 32'(cyc_tab[i].plot));
      chk($sformatf("t1_grant[%0d]", i), 32'(grant), 32'(cyc_tab[i].grant));
      chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(cyc_tab[i].busy));
      chk($sformatf("t1_terr[%0d]", i), 32'(timeout_err), 32'(cyc_tab[i].terr));
    end
    unit_done = '0;

    // Fairness with all four requesting; done 5 cycles after each plot.
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      oh  = 4'(1 << (n % 4));
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (plot == 4'b0000 && cnt < 20);
      chk($sformatf("t2_lat[%0d]", n), 32'(cnt), (n == 0) ? 32'd1 : 32'd2);
      chk($sformatf("t2_plot[%0d]", n), 32'(plot), 32'(oh));
      chk($sformatf("t2_grant[%0d]", n), 32'(grant), 32'(oh));
      for (int k = 0; k < 4; k++) step();
      unit_done = oh;
      step();
      unit_done = '0;
      chk($sformatf("t2_gap[%0d]", n), 32'(grant), 32'd0);
    end

    // Mux: unit 2 granted, only its fields reach the adapter.
    do_reset();
    req = 4'b0100;
    step();
    chk("t3_plot", 32'(plot), 32'b0100);
    req = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      unit_x = mux_tab[i].ux; unit_y = mux_tab[i].uy;
      unit_colour = mux_tab[i].uc; unit_we = mux_tab[i].uwe;
      #1;
      chk($sformatf("t3_x[%0d]", i), 32'(vga_x), 32'(mux_tab[i].ex));
      chk($sformatf("t3_y[%0d]", i), 32'(vga_y), 32'(mux_tab[i].ey));
      chk($sformatf("t3_c[%0d]", i), 32'(vga_colour), 32'(mux_tab[i].ec));
      chk($sformatf("t3_we[%0d]", i), 32'(vga_we), 32'(mux_tab[i].ewe));
    end
    unit_done = 4'b0100;
    step();
    unit_done = '0;
    chk("t3_gap_we", 32'(vga_we), 32'd0);
    chk("t3_gap_x", 32'(vga_x), 32'd0);

    // Watchdog: unit 0 never finishes, 16 BUSY cycles then abort, unit 1 next.
    do_reset();
    req = 4'b0011;
    step();
    chk("t4_plot0", 32'(plot), 32'b0001);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("t4_hold_grant[%0d]", i), 32'(grant), 32'b0001);
      chk($sformatf("t4_hold_terr[%0d]", i), 32'(timeout_err), 32'd0);
    end
    step();
    chk("t4_terr_pulse", 32'(timeout_err), 32'd1);
    chk("t4_abort_grant", 32'(grant), 32'd0);
    step();
    chk("t4_terr_clear", 32'(timeout_err), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    step();
    chk("t4_next_plot", 32'(plot), 32'b0010);

    // Foreign done ignored; own done on the 16th BUSY cycle beats the watchdog.
    do_reset();
    req = 4'b0001;
    step();
    chk("t5_plot", 32'(plot), 32'b0001);
    for (int i = 1; i <= 16; i++) begin
      unit_done = (i == 3) ? 4'b0010 : 4'b0000;
      step();
      chk($sformatf("t5_busy[%0d]", i), 32'(grant), 32'b0001);
    end
    unit_done = 4'b0001;
    step();
    unit_done = '0;
    chk("t5_race_terr", 32'(timeout_err), 32'd0);
    chk("t5_race_grant", 32'(grant), 32'd0);
    chk("t5_race_busy", 32'(busy), 32'd1);
    step();
    chk("t5_after_terr", 32'(timeout_err), 32'd0);

    // Mid-draw reset after the pointer has moved; pointer must restart at unit 0.
    do_reset();
    req = 4'b0001;
    step();
    step();
    unit_done = 4'b0001;
    step();
    unit_done = '0;
    step();
    req = 4'b0100;
    step();
    chk("t6_plot2", 32'(plot), 32'b0100);
    step();
    unit_we = 4'b1111;
    resetn  = 1'b0;
    step();
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_plot", 32'(plot), 32'd0);
    chk("t6_rst_we", 32'(vga_we), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    req    = 4'b1111;
    step();
    chk("t6_restart", 32'(plot), 32'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
